// File: rtl/div_restoring_param.sv
// div_restoring_param: self-sequenced restoring divider with start/done handshake,
// runtime signed mode, divide-by-zero/overflow flags and remainder output.
module div_restoring_param #(
  parameter int WIDTH     = 10,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dbz,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t           state_q;
  logic [WIDTH:0]   acc_q, shift_d, trial_d;
  logic [WIDTH-1:0] quo_q, div_q, q_out_q, r_out_q, a_abs_d, b_abs_d;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q, neg_r_q, busy_q, done_q, dbz_q, ovf_q, sm_d;
  always_comb begin
    sm_d    = SIGNED_EN && signed_mode;
    a_abs_d = (sm_d && a_in[WIDTH-1]) ? -a_in : a_in;
    b_abs_d = (sm_d && b_in[WIDTH-1]) ? -b_in : b_in;
    shift_d = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, div_q};
  end
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          dbz_q <= 1'b0;
          ovf_q <= 1'b0;
          if (b_in == '0) begin
            dbz_q   <= 1'b1;
            q_out_q <= '1;
            r_out_q <= a_in;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (sm_d && a_in == MIN && b_in == '1) begin
            ovf_q   <= 1'b1;
            q_out_q <= MIN;
            r_out_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            q_out_q <= '0;
            r_out_q <= '0;
            quo_q   <= a_abs_d;
            div_q   <= b_abs_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= sm_d && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            neg_r_q <= sm_d && a_in[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= ITER;
          end
        end
        ITER: begin
          acc_q   <= trial_d[WIDTH] ? shift_d : trial_d;
          quo_q   <= {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
          cnt_q   <= cnt_q + CW'(1);
          state_q <= (cnt_q == CW'(WIDTH-1)) ? FIX : ITER;
        end
        FIX: begin
          q_out_q <= neg_q_q ? -quo_q : quo_q;
          r_out_q <= neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign q_out = q_out_q;
  assign r_out = r_out_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_div_restoring_param.sv
// tb_div_restoring_param: scoreboard bench for the restoring divider (WIDTH=10, signed enabled).
module tb_div_restoring_param;
  localparam int W = 10;
  typedef struct packed {logic [W-1:0] q; logic [W-1:0] r; logic dbz; logic ovf;} exp_t;
  logic         clk = 1'b0, sclr_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, dbz, ovf;
  logic [W-1:0] q_out, r_out;
  exp_t         scb[$];
  int           errors = 0, checks = 0;
  always #5 clk = ~clk;
  div_restoring_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .sclr_n(sclr_n), .start(start), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .q_out(q_out), .r_out(r_out), .dbz(dbz), .ovf(ovf)
  );
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic sm);
    exp_t e;
    logic signed [W-1:0] sa, sd;
    sa = a;
    sd = b;
    e = '0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (sm && a == 10'h200 && b == 10'h3FF) begin
      e.q = 10'h200; e.r = '0; e.ovf = 1'b1;
    end else if (!sm) begin
      e.q = a / b; e.r = a % b;
    end else begin
      e.q = sa / sd; e.r = sa % sd;
    end
    return e;
  endfunction
  // drives one start pulse; returns at the negedge after the start-sampling edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
    scb.push_back(model(a, b, sm));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); signed_mode = ~sm;
  endtask
  task automatic wait_done(output int lat, output int nb);
    lat = 0; nb = 0;
    while (done !== 1'b1 && lat < 40) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    sclr_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, dbz, ovf, q_out, r_out} !== '0)
      $display("FAIL reset busy=%b done=%b dbz=%b ovf=%b q=%h r=%h expected all 0", busy, done, dbz, ovf, q_out, r_out);
    if ({busy, done, dbz, ovf, q_out, r_out} !== '0) errors++;
    sclr_n = 1'b1;
  endtask
  task automatic test_unsigned;
    logic [W-1:0] ta [4] = '{10'd1000, 10'd1023, 10'd3, 10'h200};
    logic [W-1:0] tb [4] = '{10'd7, 10'd1, 10'd1023, 10'h3FF};
    exp_t e;
    int lat, nb;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], 1'b0);
      wait_done(lat, nb);
      e = scb.pop_front();
      checks++;
      if ({q_out, r_out, dbz, ovf} !== e) begin
        errors++;
        $display("FAIL unsigned a=%0d b=%0d got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b", ta[i], tb[i], q_out, r_out, dbz, ovf, e.q, e.r, e.dbz, e.ovf);
      end
      checks++;
      if (lat != 11 || nb != 11) begin
        errors++;
        $display("FAIL unsigned_latency a=%0d got lat=%0d busy=%0d expected 11/11", ta[i], lat, nb);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done=%b expected 0", done);
      end
    end
  endtask
  task automatic test_signed;
    logic [W-1:0] ta [6] = '{10'h39C, 10'd100, 10'h39C, 10'h3FF, 10'h201, 10'd511};
    logic [W-1:0] tb [6] = '{10'd7, 10'h3F9, 10'h3F9, 10'd2, 10'h3FF, 10'h3FD};
    exp_t e;
    int lat, nb;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      wait_done(lat, nb);
      e = scb.pop_front();
      checks++;
      if ({q_out, r_out, dbz, ovf} !== e) begin
        errors++;
        $display("FAIL signed a=%h b=%h got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b", ta[i], tb[i], q_out, r_out, dbz, ovf, e.q, e.r, e.dbz, e.ovf);
      end
      checks++;
      if (lat != 11) begin
        errors++;
        $display("FAIL signed_latency a=%h got lat=%0d expected 11", ta[i], lat);
      end
    end
  endtask
  task automatic test_shortcuts;
    logic [W-1:0] ta [3] = '{10'h155, 10'h155, 10'h200};
    logic [W-1:0] tb [3] = '{10'h000, 10'h000, 10'h3FF};
    logic         ts [3] = '{1'b0, 1'b1, 1'b1};
    exp_t e;
    int lat, nb;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_done(lat, nb);
      e = scb.pop_front();
      checks++;
      if ({q_out, r_out, dbz, ovf} !== e) begin
        errors++;
        $display("FAIL shortcut a=%h b=%h s=%b got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b", ta[i], tb[i], ts[i], q_out, r_out, dbz, ovf, e.q, e.r, e.dbz, e.ovf);
      end
      checks++;
      if (lat != 0 || nb != 0) begin
        errors++;
        $display("FAIL shortcut_latency a=%h b=%h got lat=%0d busy=%0d expected 0/0", ta[i], tb[i], lat, nb);
      end
    end
  endtask
  task automatic test_ignore_start;
    exp_t e;
    int lat, nb, extra;
    start_op(10'd1000, 10'd7, 1'b0);
    repeat (3) @(negedge clk);
    a_in = 10'd5; b_in = 10'd1; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    e = scb.pop_front();
    checks++;
    if ({q_out, r_out, dbz, ovf} !== e || lat != 7) begin
      errors++;
      $display("FAIL ignore_start got q=%h r=%h lat=%0d expected q=%h r=%h lat=7", q_out, r_out, lat, e.q, e.r);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      extra += int'(done) + int'(busy);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start_queued got activity=%0d expected 0", extra);
    end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    int lat, nb;
    start_op(10'd1000, 10'd7, 1'b0);
    wait_done(lat, nb);
    e = scb.pop_front();
    checks++;
    if ({q_out, r_out, dbz, ovf} !== e) begin
      errors++;
      $display("FAIL b2b_first got q=%h r=%h expected q=%h r=%h", q_out, r_out, e.q, e.r);
    end
    a_in = 10'h39C; b_in = 10'd7; signed_mode = 1'b1; start = 1'b1;
    scb.push_back(model(10'h39C, 10'd7, 1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); signed_mode = 1'b0;
    wait_done(lat, nb);
    e = scb.pop_front();
    checks++;
    if ({q_out, r_out, dbz, ovf} !== e || lat != 11) begin
      errors++;
      $display("FAIL b2b_second got q=%h r=%h lat=%0d expected q=%h r=%h lat=11", q_out, r_out, lat, e.q, e.r);
    end
  endtask
  task automatic test_reset_abort;
    int lat, nb, extra;
    start_op(10'd1000, 10'd7, 1'b0);
    void'(scb.pop_back());
    repeat (4) @(negedge clk);
    sclr_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, dbz, ovf, q_out, r_out} !== '0) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b dbz=%b ovf=%b q=%h r=%h expected all 0", busy, done, dbz, ovf, q_out, r_out);
    end
    sclr_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done) + int'(busy);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_no_done got activity=%0d expected 0", extra);
    end
    start_op(10'h155, 10'h000, 1'b0);
    void'(scb.pop_back());
    wait_done(lat, nb);
    @(negedge clk);
    sclr_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, dbz, ovf, q_out, r_out} !== '0) begin
      errors++;
      $display("FAIL idle_reset dbz=%b q=%h r=%h expected all 0", dbz, q_out, r_out);
    end
    sclr_n = 1'b1;
  endtask
  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_shortcuts;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
